// File: rtl/window_line_buffer_if.sv
// window_line_buffer_if: input-word and output-window handshakes of the sliding-window line buffer.
interface window_line_buffer_if #(
  parameter int DATA_W     = 8,
  parameter int K          = 4,
  parameter int WORD_ELEMS = 4
);
  logic [WORD_ELEMS*DATA_W-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [K*K*DATA_W-1:0]        out_window;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_row_last;
  logic                         out_last;
  logic                         frame_done;
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_row_last, out_last, frame_done
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_row_last, out_last, frame_done
  );
endinterface

// File: rtl/window_line_buffer.sv
// window_line_buffer: holds K rows of a feature map and streams every KxK window at STRIDE,
// sliding down one row at a time by refilling only the newest row.
module window_line_buffer #(
  parameter int DATA_W     = 8,
  parameter int K          = 4,
  parameter int ROW_LEN    = 16,
  parameter int WORD_ELEMS = 4,
  parameter int STRIDE     = 1,
  parameter int NUM_ROWS   = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  window_line_buffer_if.slave  bus
);
  localparam int WPR   = ROW_LEN / WORD_ELEMS;
  localparam int WCOLS = (ROW_LEN - K) / STRIDE + 1;
  localparam int WROWS = NUM_ROWS - K + 1;
  localparam int CMAX  = (WCOLS - 1) * STRIDE;
  localparam int WW    = WPR > 1 ? $clog2(WPR) : 1;
  localparam int RW    = K > 1 ? $clog2(K) : 1;
  localparam int CLW   = CMAX > 0 ? $clog2(CMAX + 1) : 1;
  localparam int WRW   = WROWS > 1 ? $clog2(WROWS) : 1;
  localparam int CW    = ROW_LEN > 1 ? $clog2(ROW_LEN) : 1;

  typedef enum logic [1:0] {FILL, EMIT, REFILL} state_t;

  state_t                r_state, w_next;
  logic [DATA_W-1:0]     r_mem [K][ROW_LEN];
  logic [WW-1:0]         r_word;
  logic [RW-1:0]         r_row;
  logic [CLW-1:0]        r_col;
  logic [WRW-1:0]        r_wrow;
  logic                  r_en;
  logic                  r_done;
  logic                  w_acc_in, w_acc_out, w_fill_end, w_row_last, w_last;
  logic [K*K*DATA_W-1:0] w_win;

  assign w_acc_in   = bus.in_valid && bus.in_ready;
  assign w_acc_out  = bus.out_valid && bus.out_ready;
  assign w_fill_end = w_acc_in && r_row == RW'(K - 1) && r_word == WW'(WPR - 1);
  assign w_row_last = r_col == CLW'(CMAX);
  assign w_last     = w_row_last && r_wrow == WRW'(WROWS - 1);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= FILL;
    else       r_state <= clr ? FILL : w_next;

  always_comb begin
    w_next = r_state;
    if (r_state != EMIT && w_fill_end) w_next = EMIT;
    if (r_state == EMIT && w_acc_out && w_row_last) w_next = w_last ? FILL : REFILL;
  end

  // r_row parks at K-1 after the initial fill so every refill lands in the newest row
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_mem  <= '{default: '0};
      r_word <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_wrow <= '0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_en   <= 1'b1;
      r_done <= 1'b0;
      if (clr) begin
        r_word <= '0;
        r_row  <= '0;
        r_col  <= '0;
        r_wrow <= '0;
      end else begin
        if (w_acc_in) begin
          for (int j = 0; j < WORD_ELEMS; j++)
            r_mem[r_row][CW'(int'(r_word) * WORD_ELEMS + j)] <= bus.in_data[(WORD_ELEMS-1-j)*DATA_W +: DATA_W];
          r_word <= r_word == WW'(WPR - 1) ? '0 : r_word + 1'b1;
          if (r_word == WW'(WPR - 1) && r_row != RW'(K - 1)) r_row <= r_row + 1'b1;
        end
        if (w_acc_out) begin
          r_col <= w_row_last ? '0 : r_col + CLW'(STRIDE);
          if (w_last) begin
            r_wrow <= '0;
            r_row  <= '0;
            r_word <= '0;
            r_done <= 1'b1;
          end else if (w_row_last) begin
            r_wrow <= r_wrow + 1'b1;
            for (int i = 0; i < K - 1; i++) r_mem[RW'(i)] <= r_mem[RW'(i + 1)];
            r_mem[RW'(K - 1)] <= '{default: '0};
          end
        end
      end
    end

  always_comb begin
    w_win = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w_win[(K*K-1-(r*K+c))*DATA_W +: DATA_W] = r_mem[RW'(r)][CW'(int'(r_col) + c)];
  end

  assign bus.in_ready     = r_en && r_state != EMIT;
  assign bus.out_valid    = r_state == EMIT;
  assign bus.out_window   = bus.out_valid ? w_win : '0;
  assign bus.out_row_last = bus.out_valid && w_row_last;
  assign bus.out_last     = bus.out_valid && w_last;
  assign bus.frame_done   = r_done;
endmodule
